// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel stream multiplexer.
package mux_pkg;

  // Round-robin pointer value after reset: the first rr grant scans from channel 0.
  localparam int unsigned PTR_RST = 0;

  // Channel-index width, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: the first requester found scanning ptr, ptr+1, .. with wrap.
module rr_pick
  import mux_pkg::*;
#(
  parameter int unsigned NCH = 3,
  localparam int unsigned SELW = clog2_min1(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] g,
  output logic            any
);

  int unsigned p;
  int unsigned d;
  int unsigned best;

  // The winner is the requester at the smallest rotated distance from ptr.
  always_comb begin
    g    = '0;
    p    = 32'(ptr);
    d    = 0;
    best = NCH;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (req[i]) begin
        d = (i >= p) ? (i - p) : (i + NCH - p);
        if (d < best) begin
          best = d;
          g    = SELW'(i);
        end
      end
    end
    any = |req;
  end

endmodule

// File: rtl/mux_arb_n.sv
// Registered N-channel valid/ready multiplexer: fixed-select or round-robin grant.
module mux_arb_n
  import mux_pkg::*;
#(
  parameter int unsigned NCH   = 3,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SELW = clog2_min1(NCH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 rr_en,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sel_err
);

  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_ch_q;
  logic             out_valid_q;
  logic             sel_err_q;
  logic [SELW-1:0]  ptr_q;

  logic [SELW-1:0]  rr_g;
  logic             rr_any;
  logic             sel_oor;
  logic             fix_vld;
  logic [SELW-1:0]  g;
  logic             gnt_vld;
  logic             load;
  logic [WIDTH-1:0] g_data;
  logic [SELW-1:0]  ptr_d;

  rr_pick #(
    .NCH (NCH)
  ) u_rr_pick (
    .req (in_valid),
    .ptr (ptr_q),
    .g   (rr_g),
    .any (rr_any)
  );

  assign sel_oor = (32'(sel) >= NCH);
  assign load    = ~out_valid_q | out_ready;

  // Out-of-range sel matches no channel, so fix_vld stays 0 and nothing transfers.
  always_comb begin
    fix_vld = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (sel == SELW'(i)) fix_vld = in_valid[i];
    end
  end

  assign g       = rr_en ? rr_g : sel;
  assign gnt_vld = rr_en ? rr_any : fix_vld;

  always_comb begin
    g_data   = '0;
    in_ready = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (g == SELW'(i)) begin
        g_data      = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = load & gnt_vld;
      end
    end
  end

  assign ptr_d = (32'(rr_g) + 1 == NCH) ? '0 : rr_g + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      ptr_q       <= SELW'(PTR_RST);
    end else begin
      sel_err_q <= ~rr_en & sel_oor;
      if (load) begin
        out_valid_q <= gnt_vld;
        if (gnt_vld) begin
          out_data_q <= g_data;
          out_ch_q   <= g;
          if (rr_en) ptr_q <= ptr_d;
        end
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n with NCH=3, WIDTH=8.
module tb_mux_arb_n;

  localparam int unsigned NCH   = 3;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned SELW  = 2;

  logic                 clk;
  logic                 reset_n;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 rr_en;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;
  logic                 sel_err;

  int checks;
  int failures;

  mux_arb_n #(
    .NCH   (NCH),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rr_en     (rr_en),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge so registered outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_rr[5];
  int exp_wrap[3];

  initial begin
    checks    = 0;
    failures  = 0;
    exp_rr    = '{0, 1, 2, 0, 1};
    exp_wrap  = '{2, 0, 2};
    reset_n   = 1'b0;
    in_data   = {8'h33, 8'h22, 8'h11};
    in_valid  = '0;
    rr_en     = 1'b0;
    sel       = '0;
    out_ready = 1'b0;

    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_ch", 32'(out_ch), 0);
    check("rst_sel_err", 32'(sel_err), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Fixed select of channel 1.
    tick();
    sel       = 2'd1;
    in_valid  = 3'b111;
    out_ready = 1'b1;
    #1;
    check("t1_in_ready", 32'(in_ready), 32'b010);
    tick();
    check("t1_out_data", 32'(out_data), 32'h22);
    check("t1_out_ch", 32'(out_ch), 1);
    check("t1_out_valid", 32'(out_valid), 1);
    check("t1_sel_err", 32'(sel_err), 0);

    // Out-of-range select, then recovery on sel=0.
    sel = 2'd3;
    #1;
    check("t2_in_ready_oor", 32'(in_ready), 0);
    tick();
    check("t2_sel_err", 32'(sel_err), 1);
    check("t2_out_valid", 32'(out_valid), 0);
    check("t2_out_data_hold", 32'(out_data), 32'h22);
    sel = 2'd0;
    #1;
    check("t2_in_ready_ch0", 32'(in_ready), 32'b001);
    tick();
    check("t2_out_ch", 32'(out_ch), 0);
    check("t2_out_data", 32'(out_data), 32'h11);
    check("t2_out_valid", 32'(out_valid), 1);
    check("t2_sel_err_clr", 32'(sel_err), 0);

    // Round-robin from reset, all channels requesting.
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    rr_en   = 1'b1;
    #1;
    check("t3_in_ready", 32'(in_ready), 32'b001);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("t3_out_ch_%0d", k), 32'(out_ch), 32'(exp_rr[k]));
      check($sformatf("t3_out_valid_%0d", k), 32'(out_valid), 1);
    end

    // Move ptr to 1, then wrap across idle channel 1.
    in_valid = 3'b001;
    tick();
    check("t4_prep_ch", 32'(out_ch), 0);
    in_valid = 3'b101;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t4_out_ch_%0d", k), 32'(out_ch), 32'(exp_wrap[k]));
    end

    // Back-pressure for three cycles.
    in_valid  = 3'b111;
    out_ready = 1'b0;
    #1;
    check("t5_in_ready_stall", 32'(in_ready), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t5_hold_data_%0d", k), 32'(out_data), 32'h33);
      check($sformatf("t5_hold_ch_%0d", k), 32'(out_ch), 2);
      check($sformatf("t5_hold_valid_%0d", k), 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    check("t5_in_ready_resume", 32'(in_ready), 32'b001);
    tick();
    check("t5_resume_ch", 32'(out_ch), 0);
    check("t5_resume_data", 32'(out_data), 32'h11);

    // Fixed mode must not move ptr (currently 1).
    rr_en = 1'b0;
    sel   = 2'd2;
    tick();
    check("t7_fixed_ch", 32'(out_ch), 2);
    rr_en = 1'b1;
    tick();
    check("t7_rr_after_fixed", 32'(out_ch), 1);

    // Asynchronous reset mid-stream, ptr is 2 here.
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(out_valid), 0);
    check("t6_async_data", 32'(out_data), 0);
    check("t6_async_ch", 32'(out_ch), 0);
    #1;
    reset_n = 1'b1;
    tick();
    check("t6_first_grant_ch", 32'(out_ch), 0);
    check("t6_first_grant_valid", 32'(out_valid), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
